// File: rtl/mac_chunk_sequencer_if.sv
// rtl/mac_chunk_sequencer_if.sv - controller, weight-memory and MAC signals of the chunk sequencer
interface mac_chunk_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int N_CHUNKS = 5,
    parameter int ACC_W    = 12,
    parameter int AW       = 3
);
    logic                   start;
    logic [5*N_CHUNKS-1:0]  pixels;
    logic [ACC_W-1:0]       threshold;
    logic                   w_rd_en;
    logic [AW-1:0]          w_addr;
    logic [5*WIDTH-1:0]     w_rd_data;
    logic [4:0]             mac_p;
    logic [5*WIDTH-1:0]     mac_w;
    logic [WIDTH-1:0]       mac_sum;
    logic                   busy;
    logic                   done;
    logic                   spike;
    logic [ACC_W-1:0]       acc_out;
    logic                   sat;

    // master is the environment (layer controller, weight ROM, MAC); slave is the sequencer
    modport master (
        output start, pixels, threshold, w_rd_data, mac_sum,
        input  w_rd_en, w_addr, mac_p, mac_w, busy, done, spike, acc_out, sat
    );

    modport slave (
        input  start, pixels, threshold, w_rd_data, mac_sum,
        output w_rd_en, w_addr, mac_p, mac_w, busy, done, spike, acc_out, sat
    );
endinterface

// File: rtl/mac_chunk_sequencer.sv
// rtl/mac_chunk_sequencer.sv - walks one neuron's receptive field through a 5-input MAC
// and accumulates the chunk sums into a saturating membrane register.
module mac_chunk_sequencer #(
    parameter int WIDTH    = 8,
    parameter int N_CHUNKS = 5,
    parameter int ACC_W    = 12,
    parameter int MAC_LAT  = 1,
    parameter int AW       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_chunk_sequencer_if.slave  bus
);
    localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST   = LW'(MAC_LAT - 1);
    localparam logic [AW-1:0] LAST_CHUNK = AW'(N_CHUNKS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRIVE, S_WAIT, S_ACC, S_FIRE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [AW-1:0]          r_chunk;
    logic [LW-1:0]          r_wait;
    logic [5*N_CHUNKS-1:0]  r_pix;
    logic [ACC_W-1:0]       r_thresh;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_acc_out;
    logic                   r_sat;
    logic [4:0]             r_mac_p;
    logic [5*WIDTH-1:0]     r_mac_w;

    logic [ACC_W:0]         w_sum;
    logic                   w_clamp;
    logic [ACC_W-1:0]       w_acc_next;

    // one guard bit: overflow shows up as the two top bits disagreeing
    assign w_sum   = {r_acc[ACC_W-1], r_acc}
                   + {{(ACC_W+1-WIDTH){bus.mac_sum[WIDTH-1]}}, bus.mac_sum};
    assign w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_clamp) begin
            w_acc_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_FETCH;
            S_FETCH: w_next = S_DRIVE;
            S_DRIVE: w_next = S_WAIT;
            S_WAIT:  if (r_wait == LAT_LAST) w_next = S_ACC;
            S_ACC:   w_next = (r_chunk == LAST_CHUNK) ? S_FIRE : S_FETCH;
            S_FIRE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chunk   <= '0;
            r_wait    <= '0;
            r_pix     <= '0;
            r_thresh  <= '0;
            r_acc     <= '0;
            r_acc_out <= '0;
            r_sat     <= 1'b0;
            r_mac_p   <= '0;
            r_mac_w   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pix    <= bus.pixels;
                        r_thresh <= bus.threshold;
                        r_acc    <= '0;
                        r_chunk  <= '0;
                        r_sat    <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    // latched pixels shift down so chunk c always sits in the low 5 bits
                    r_mac_w <= bus.w_rd_data;
                    r_mac_p <= r_pix[4:0];
                    r_pix   <= r_pix >> 5;
                    r_wait  <= '0;
                end
                S_WAIT: begin
                    r_wait <= r_wait + LW'(1);
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    if (w_clamp) begin
                        r_sat <= 1'b1;
                    end
                    if (r_chunk != LAST_CHUNK) begin
                        r_chunk <= r_chunk + AW'(1);
                    end
                end
                S_FIRE: begin
                    r_acc_out <= r_acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.w_rd_en = (r_state == S_FETCH);
    assign bus.w_addr  = r_chunk;
    assign bus.mac_p   = r_mac_p;
    assign bus.mac_w   = r_mac_w;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_FIRE);
    assign bus.spike   = (r_state == S_FIRE) && ($signed(r_acc) >= $signed(r_thresh));
    assign bus.acc_out = r_acc_out;
    assign bus.sat     = r_sat;
endmodule

// File: tb/tb_mac_chunk_sequencer.sv
// tb/tb_mac_chunk_sequencer.sv - directed bench: nominal (lat 1), lat 3, and 20-chunk saturation instances
module tb_mac_chunk_sequencer;
    logic clk;
    logic rst;

    mac_chunk_sequencer_if #(.WIDTH(8), .N_CHUNKS(5),  .ACC_W(12), .AW(3)) ifa ();
    mac_chunk_sequencer_if #(.WIDTH(8), .N_CHUNKS(5),  .ACC_W(12), .AW(3)) ifb ();
    mac_chunk_sequencer_if #(.WIDTH(8), .N_CHUNKS(20), .ACC_W(12), .AW(5)) ifc ();

    mac_chunk_sequencer #(.WIDTH(8), .N_CHUNKS(5), .ACC_W(12), .MAC_LAT(1), .AW(3))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mac_chunk_sequencer #(.WIDTH(8), .N_CHUNKS(5), .ACC_W(12), .MAC_LAT(3), .AW(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mac_chunk_sequencer #(.WIDTH(8), .N_CHUNKS(20), .ACC_W(12), .MAC_LAT(1), .AW(5))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [39:0] wmem [8];
    logic [7:0]  pipe_b [3];
    logic [7:0]  mac_c_val;

    function automatic logic [7:0] mac_f(input logic [4:0] p, input logic [39:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 5; i++) begin
            if (p[i]) s += int'($signed(w[8*i +: 8]));
        end
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (ifa.w_rd_en) ifa.w_rd_data <= wmem[ifa.w_addr];
        if (ifb.w_rd_en) ifb.w_rd_data <= wmem[ifb.w_addr];
        ifa.mac_sum <= mac_f(ifa.mac_p, ifa.mac_w);
        pipe_b[0]   <= mac_f(ifb.mac_p, ifb.mac_w);
        pipe_b[1]   <= pipe_b[0];
        pipe_b[2]   <= pipe_b[1];
    end
    assign ifb.mac_sum   = pipe_b[2];
    assign ifc.w_rd_data = '0;
    assign ifc.mac_sum   = mac_c_val;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic done_of(input int s);
        case (s)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    function automatic logic spike_of(input int s);
        case (s)
            0:       return ifa.spike;
            1:       return ifb.spike;
            default: return ifc.spike;
        endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       ifa.start = v;
            1:       ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    // start sampled at edge k; returns n where done is seen in cycle k+n
    task automatic run(input int s, input bit chg, output int lat, output bit spk);
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        if (chg) begin
            ifa.pixels    = ~ifa.pixels;
            ifa.threshold = '0;
        end
        lat = 1;
        while (!done_of(s) && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        spk = spike_of(s);
        @(posedge clk); #1;
    endtask

    task automatic load_flat();
        for (int i = 0; i < 8; i++) wmem[i] = {5{8'h10}};
    endtask

    int lat;
    bit spk;
    int n_done;

    initial begin
        ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
        ifa.pixels = '1;  ifb.pixels = '1;  ifc.pixels = '1;
        ifa.threshold = '0; ifb.threshold = '0; ifc.threshold = '0;
        mac_c_val = 8'd0;
        load_flat();
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ctrl_a", {ifa.w_rd_en, ifa.w_addr, ifa.mac_p, ifa.busy, ifa.done,
                               ifa.spike, ifa.acc_out, ifa.sat}, 0);
            chk("rst_mac_w_a", ifa.mac_w, 0);
            chk("rst_rd_en_bc", {ifb.w_rd_en, ifc.w_rd_en, ifb.busy, ifc.busy}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", ifa.busy, 0);

        // nominal: 5 chunks x 0x50 = 400 >= 384
        ifa.pixels = '1;
        ifa.threshold = 12'd384;
        run(0, 1'b0, lat, spk);
        chk("a_nom_lat", lat, 21);
        chk("a_nom_spike", spk, 1);
        chk("a_nom_acc", $signed(ifa.acc_out), 400);
        chk("a_nom_sat", ifa.sat, 0);
        chk("a_nom_busy_after", ifa.busy, 0);

        // mixed pixels chunk 0 only: 64+16+8-16 = 72 < 100
        wmem[0] = {8'hF0, 8'h08, 8'h10, 8'h20, 8'h40};
        ifa.pixels = 25'b11101;
        ifa.threshold = 12'd100;
        run(0, 1'b0, lat, spk);
        chk("a_mix_lat", lat, 21);
        chk("a_mix_spike", spk, 0);
        chk("a_mix_acc", $signed(ifa.acc_out), 72);

        // MAC_LAT=3: early sampling of chunk 1 would pick up chunk 0's 72 again
        ifb.pixels = 25'b11101;
        ifb.threshold = 12'd100;
        run(1, 1'b0, lat, spk);
        chk("b_mix_lat", lat, 31);
        chk("b_mix_spike", spk, 0);
        chk("b_mix_acc", $signed(ifb.acc_out), 72);
        load_flat();
        ifb.pixels = '1;
        ifb.threshold = 12'd384;
        run(1, 1'b0, lat, spk);
        chk("b_nom_acc", $signed(ifb.acc_out), 400);
        chk("b_nom_spike", spk, 1);

        // saturation: 20 x 127 and 20 x -128
        mac_c_val = 8'd127;
        ifc.threshold = 12'd0;
        run(2, 1'b0, lat, spk);
        chk("c_pos_lat", lat, 81);
        chk("c_pos_acc", $signed(ifc.acc_out), 2047);
        chk("c_pos_sat", ifc.sat, 1);
        mac_c_val = 8'h80;
        run(2, 1'b0, lat, spk);
        chk("c_neg_acc", $signed(ifc.acc_out), -2048);
        chk("c_neg_sat", ifc.sat, 1);
        chk("c_neg_spike", spk, 0);

        // abort: start ignored in chunk 2 WAIT, reset in chunk 3, no done
        ifa.pixels = '1;
        ifa.threshold = 12'd384;
        n_done = 0;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ifa.done) n_done++;
        end
        chk("abort_in_wait_rd_en", ifa.w_rd_en, 0);
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        @(posedge clk); #1;
        chk("abort_chunk3_fetch", {ifa.w_rd_en, ifa.w_addr}, {1'b1, 3'd3});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", ifa.busy, 0);
        chk("abort_acc_out", ifa.acc_out, 0);
        repeat (30) begin
            @(posedge clk); #1;
            if (ifa.done) n_done++;
        end
        chk("abort_no_done", n_done, 0);

        // fresh run, pixels/threshold scrambled right after start: still 72, no spike
        wmem[0] = {8'hF0, 8'h08, 8'h10, 8'h20, 8'h40};
        ifa.pixels = 25'b11101;
        ifa.threshold = 12'd100;
        run(0, 1'b1, lat, spk);
        chk("fresh_lat", lat, 21);
        chk("fresh_acc", $signed(ifa.acc_out), 72);
        chk("fresh_spike", spk, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mac_chunk_sequencer.md
# mac_chunk_sequencer

Sequences the 5-input binary-pixel MAC (five 1-bit pixels × five signed Q1.7 weights → signed Q1.7 partial sum) across one neuron's full receptive field. It latches a pixel vector and threshold on `start` and fetches one 5-weight word per chunk from a synchronous weight memory. Each chunk is presented to the MAC and the partial sums are accumulated into a saturating membrane register. At the end of the run the block emits a spike decision. It sits between the layer controller (start/done) and one MAC instance plus its weight ROM.

## Interface
- `WIDTH`, 8, weight and MAC-sum width (Q1.7)
- `N_CHUNKS`, 5, number of 5-pixel chunks per neuron (N_INPUTS = 5·N_CHUNKS)
- `ACC_W`, 12, accumulator width (signed, Q(ACC_W-7).7)
- `MAC_LAT`, 1, MAC input-to-`sum` latency in clocks, ≥1
- `AW`, 3, weight-memory address width, 2^AW ≥ N_CHUNKS
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `pixels`  in  5·N_CHUNKS  binary input pixels; bits [5c+4:5c] form chunk c
- `threshold`  in  ACC_W  signed firing threshold, same Q format as accumulator
- `w_rd_en`  out  1  weight-memory read enable
- `w_addr`  out  AW  weight-memory address (= chunk index)
- `w_rd_data`  in  5·WIDTH  weight word, valid the cycle after `w_rd_en`; weight i at [WIDTH·i +: WIDTH]
- `mac_p`  out  5  pixels to MAC
- `mac_w`  out  5·WIDTH  weights to MAC
- `mac_sum`  in  WIDTH  signed MAC result, Q1.7
- `busy`  out  1  high from the first FETCH through FIRE
- `done`  out  1  one-cycle pulse, in FIRE
- `spike`  out  1  one-cycle pulse with `done` when acc ≥ threshold
- `acc_out`  out  ACC_W  final accumulator, held until next start
- `sat`  out  1  sticky per run: an accumulate clamped

## Operation
- States: IDLE, FETCH, DRIVE, WAIT, ACC, FIRE.
- IDLE: `start`=1 → latch `pixels` and `threshold`, clear acc, chunk=0, clear `sat` → FETCH.
- FETCH: `w_rd_en`=1, `w_addr`=chunk → DRIVE.
- DRIVE: register `mac_w` ← `w_rd_data`, `mac_p` ← latched chunk pixels → WAIT.
- WAIT: hold for MAC_LAT cycles (counter), then → ACC.
- ACC: acc ← sat(acc + sign_ext(`mac_sum`)). If chunk = N_CHUNKS-1 → FIRE, else chunk+1 → FETCH.
- FIRE: `done`=1. `spike` = (acc ≥ latched threshold, signed compare). `acc_out` ← acc → IDLE.
- Saturation: the sum is computed at ACC_W+1 bits. Results above 2^(ACC_W-1)-1 clamp to the maximum and results below -2^(ACC_W-1) clamp to the minimum. Either clamp sets `sat`.
- All-zero pixel chunks are still issued; timing is data-independent.
- `start` outside IDLE is ignored. Pixel or threshold changes after the start edge have no effect on the current run.
- `mac_p`/`mac_w` hold their last values outside DRIVE. `w_rd_en` is 0 outside FETCH.

## Timing
- Reset: state=IDLE, chunk=0. `w_rd_en`, `w_addr`, `mac_p`, `mac_w`, `busy`, `done`, `spike`, `acc_out`, `sat` all 0.
- `rst` asserted mid-run aborts on the next edge to IDLE with the reset values above. No `done` is issued.
- Per chunk: 3+MAC_LAT cycles. `start` sampled at edge k → FETCH in cycle k+1 → `done`/`spike` high in cycle k+1+N_CHUNKS·(3+MAC_LAT). The default is k+21.
- The MAC sees new `mac_p`/`mac_w` from the cycle after DRIVE. `mac_sum` is sampled in ACC, exactly MAC_LAT cycles later.
- `start` high in the FIRE cycle is ignored. `start` in the following IDLE cycle begins a new run, so the minimum run-to-run spacing is N_CHUNKS·(3+MAC_LAT)+2 cycles.
- `busy` deasserts in the cycle after FIRE.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → all outputs 0 and no FETCH issued. Release → run starts on the next sampled `start`.
- Nominal accumulate: all weights 0x10 (0.125) and all pixels 1 give a MAC model sum of 0x50 per chunk. With threshold 384 → `acc_out`=400, `spike`=1, `done` at k+21, `sat`=0.
- Below threshold with mixed pixels: chunk 0 pixels 10111 with weights 0x40,0x20,0x10,0x08,0xF0 gives 0.5+0.125+0.0625-0.125=0.5625 (72). Remaining chunks have pixels 0. With threshold 100 → `acc_out`=72, `spike`=0.
- Saturation: N_CHUNKS=20, AW=5, and the MAC model returns 127 every chunk → `acc_out`=2047 and `sat`=1. A negative variant returns -128 every chunk → `acc_out`=-2048 and `sat`=1.
- Latency sweep: MAC_LAT=1, 3 → `mac_sum` is sampled exactly MAC_LAT cycles after the DRIVE-registered inputs, and `done` moves by N_CHUNKS·2 cycles.
- Abort and ignore: pulse `start` during WAIT of chunk 2, then assert `rst` in chunk 3 → no `done`. A fresh `start` then yields a correct full-length run. Changing `pixels` mid-run does not alter the result.
